pc_redirect_sequencer: RTL and testbench

Drives the program counter's redirect inputs (interrupt force-to-zero, stack-return load, stall) and performs the stack memory traffic behind CALL, RET, RTI and hardware interrupt entry. It pushes return addresses and flags to the data-memory stack, then pops them back and presents the restored 32-bit PC for a one-cycle redirect. It sits between decode/interrupt logic and the PC register, and owns the stack pointer.

---
 rtl/pc_redirect_sequencer_if.sv | 23 ++
 rtl/pc_redirect_sequencer.sv | 173 +++++++++++++++++
 tb/tb_pc_redirect_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_redirect_sequencer_if.sv
// Stack-memory port used by pc_redirect_sequencer: request/ready handshake with
// 16-bit words; the sequencer is the master.
interface pc_redirect_sequencer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/pc_redirect_sequencer.sv
// Sequences CALL/RET/RTI/interrupt stack traffic and drives the PC redirect,
// force-to-zero and stall controls; owns the stack pointer.
module pc_redirect_sequencer #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned SP_INIT = 2047
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     call_req,
  input  logic [31:0]              ret_addr,
  input  logic                     ret_req,
  input  logic                     rti_req,
  input  logic                     int_req,
  input  logic [31:0]              pc_in,
  input  logic [3:0]               flags_in,
  pc_redirect_sequencer_if.master  mem,
  output logic                     int_pulse,
  output logic                     redirect_valid,
  output logic [31:0]              redirect_pc,
  output logic                     flags_restore,
  output logic [3:0]               flags_out,
  output logic                     stall_out,
  output logic [ADDR_W-1:0]        sp
);

  typedef enum logic [3:0] {
    IDLE, PUSH_HI, PUSH_LO, PUSH_FL, INT_VEC, POP_FL, POP_LO, POP_HI, REDIRECT
  } state_t;

  state_t            state, state_n;
  logic              int_pending, is_int, is_rti, accept_int, xfer;
  logic [31:0]       pc_lat;
  logic [3:0]        flags_lat;
  logic [DATA_W-1:0] pc_lo, pc_hi;

  logic              req_c, we_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;

  assign mem.mem_req   = req_c;
  assign mem.mem_we    = we_c;
  assign mem.mem_addr  = addr_c;
  assign mem.mem_wdata = wdata_c;

  assign xfer        = req_c & mem.mem_ready;
  assign stall_out   = (state != IDLE);
  assign redirect_pc = {pc_hi, pc_lo};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n        = state;
    req_c          = 1'b0;
    we_c           = 1'b0;
    addr_c         = '0;
    wdata_c        = '0;
    int_pulse      = 1'b0;
    redirect_valid = 1'b0;
    flags_restore  = 1'b0;
    accept_int     = 1'b0;
    unique case (state)
      IDLE: begin
        if (rti_req)                     state_n = POP_FL;
        else if (ret_req)                state_n = POP_LO;
        else if (call_req)               state_n = PUSH_HI;
        else if (int_pending || int_req) begin
          state_n    = PUSH_HI;
          accept_int = 1'b1;
        end
      end
      PUSH_HI: begin
        req_c   = 1'b1;
        we_c    = 1'b1;
        addr_c  = sp;
        wdata_c = pc_lat[31:16];
        if (mem.mem_ready) state_n = PUSH_LO;
      end
      PUSH_LO: begin
        req_c   = 1'b1;
        we_c    = 1'b1;
        addr_c  = sp - ADDR_W'(1);
        wdata_c = pc_lat[15:0];
        if (mem.mem_ready) state_n = is_int ? PUSH_FL : IDLE;
      end
      PUSH_FL: begin
        req_c   = 1'b1;
        we_c    = 1'b1;
        addr_c  = sp - ADDR_W'(2);
        wdata_c = DATA_W'(flags_lat);
        if (mem.mem_ready) state_n = INT_VEC;
      end
      INT_VEC: begin
        int_pulse = 1'b1;
        state_n   = IDLE;
      end
      POP_FL: begin
        req_c  = 1'b1;
        addr_c = sp + ADDR_W'(1);
        if (mem.mem_ready) state_n = POP_LO;
      end
      // RTI pops sit one word deeper because the flags word is on top.
      POP_LO: begin
        req_c  = 1'b1;
        addr_c = sp + (is_rti ? ADDR_W'(2) : ADDR_W'(1));
        if (mem.mem_ready) state_n = POP_HI;
      end
      POP_HI: begin
        req_c  = 1'b1;
        addr_c = sp + (is_rti ? ADDR_W'(3) : ADDR_W'(2));
        if (mem.mem_ready) state_n = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        flags_restore  = is_rti;
        state_n        = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp          <= ADDR_W'(SP_INIT);
      int_pending <= 1'b0;
      is_int      <= 1'b0;
      is_rti      <= 1'b0;
      pc_lat      <= '0;
      flags_lat   <= '0;
      pc_lo       <= '0;
      pc_hi       <= '0;
      flags_out   <= '0;
    end else begin
      // Any int_req not consumed by this edge's acceptance stays pending.
      int_pending <= accept_int ? 1'b0 : (int_pending | int_req);
      if (state == IDLE) begin
        if (rti_req) begin
          is_rti <= 1'b1;
          is_int <= 1'b0;
        end else if (ret_req) begin
          is_rti <= 1'b0;
          is_int <= 1'b0;
        end else if (call_req) begin
          pc_lat <= ret_addr;
          is_rti <= 1'b0;
          is_int <= 1'b0;
        end else if (accept_int) begin
          pc_lat    <= pc_in;
          flags_lat <= flags_in;
          is_rti    <= 1'b0;
          is_int    <= 1'b1;
        end
      end
      if (xfer) begin
        case (state)
          PUSH_LO: if (!is_int) sp <= sp - ADDR_W'(2);
          PUSH_FL: sp <= sp - ADDR_W'(3);
          POP_FL:  flags_out <= mem.mem_rdata[3:0];
          POP_LO:  pc_lo <= mem.mem_rdata;
          POP_HI: begin
            pc_hi <= mem.mem_rdata;
            sp    <= sp + (is_rti ? ADDR_W'(3) : ADDR_W'(2));
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_redirect_sequencer.sv
// Self-checking bench for pc_redirect_sequencer: table-driven operation vectors,
// a stack-traffic/redirect scoreboard, and hand-built corner sequences.
module tb_pc_redirect_sequencer;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 16;

  typedef enum int {OP_CALL, OP_RET, OP_RTI, OP_INT} op_t;
  typedef struct {
    op_t         op;
    logic [31:0] arg;
    logic [3:0]  fl;
    int          busy;
    logic [31:0] sp;
  } vec_t;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [15:0] wdata;
  } mem_exp_t;
  typedef struct packed {
    logic [31:0] pc;
    logic        fr;
    logic [3:0]  fl;
  } red_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, call_req, ret_req, rti_req, int_req;
  logic [31:0]   ret_addr, pc_in, redirect_pc;
  logic [3:0]    flags_in, flags_out;
  logic          int_pulse, redirect_valid, flags_restore, stall_out;
  logic [AW-1:0] sp;

  pc_redirect_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  pc_redirect_sequencer #(.ADDR_W(AW), .DATA_W(DW), .SP_INIT(2047)) dut (
    .clk(clk), .reset(reset), .call_req(call_req), .ret_addr(ret_addr),
    .ret_req(ret_req), .rti_req(rti_req), .int_req(int_req), .pc_in(pc_in),
    .flags_in(flags_in), .mem(mem_if), .int_pulse(int_pulse),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flags_restore(flags_restore), .flags_out(flags_out),
    .stall_out(stall_out), .sp(sp)
  );

  // Stack memory with a programmable number of wait cycles per access.
  logic [15:0] mem_arr [0:4095];
  int unsigned wait_n = 0;
  int unsigned wcnt = 0;
  assign mem_if.mem_ready = mem_if.mem_req && (wcnt >= wait_n);
  assign mem_if.mem_rdata = mem_arr[mem_if.mem_addr[11:0]];
  always @(posedge clk) begin
    if (mem_if.mem_req && !mem_if.mem_ready) wcnt <= wcnt + 1;
    else                                     wcnt <= 0;
    if (mem_if.mem_req && mem_if.mem_ready && mem_if.mem_we)
      mem_arr[mem_if.mem_addr[11:0]] <= mem_if.mem_wdata;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event occurred with nothing expected", name);
  endtask

  // Scoreboard state and reference model of the stack.
  mem_exp_t    mq[$];
  red_exp_t    rq[$];
  int          pulse_exp = 0;
  logic [31:0] msp = 32'd2047;
  logic [3:0]  mflags = 4'h0;
  logic [15:0] mmem [0:4095];

  logic        hold_v = 1'b0;
  logic        h_we;
  logic [31:0] h_addr;
  logic [15:0] h_wd;

  always @(negedge clk) begin
    mem_exp_t e;
    red_exp_t r;
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && mem_if.mem_req) begin
        check("hold_addr", 64'(mem_if.mem_addr), 64'(h_addr));
        check("hold_we", 64'(mem_if.mem_we), 64'(h_we));
        check("hold_wdata", 64'(mem_if.mem_wdata), 64'(h_wd));
      end
      hold_v = mem_if.mem_req && !mem_if.mem_ready;
      h_we   = mem_if.mem_we;
      h_addr = mem_if.mem_addr;
      h_wd   = mem_if.mem_wdata;
      if (mem_if.mem_req && mem_if.mem_ready) begin
        if (mq.size() == 0) fail_now("mem_unexpected");
        else begin
          e = mq.pop_front();
          check("mem_we", 64'(mem_if.mem_we), 64'(e.we));
          check("mem_addr", 64'(mem_if.mem_addr), 64'(e.addr));
          if (e.we) check("mem_wdata", 64'(mem_if.mem_wdata), 64'(e.wdata));
        end
      end
      if (redirect_valid) begin
        if (rq.size() == 0) fail_now("redirect_unexpected");
        else begin
          r = rq.pop_front();
          check("redirect_pc", 64'(redirect_pc), 64'(r.pc));
          check("flags_restore", 64'(flags_restore), 64'(r.fr));
          check("flags_out", 64'(flags_out), 64'(r.fl));
        end
      end else if (flags_restore) begin
        fail_now("flags_restore_alone");
      end
      if (int_pulse) begin
        check("pulse_excl", 64'(redirect_valid), 64'd0);
        if (pulse_exp == 0) fail_now("int_pulse_unexpected");
        else pulse_exp--;
      end
    end
  end

  task automatic push_exp(input op_t op, input logic [31:0] arg, input logic [3:0] fl);
    case (op)
      OP_CALL: begin
        mq.push_back({1'b1, msp, arg[31:16]});
        mq.push_back({1'b1, msp - 32'd1, arg[15:0]});
        mmem[msp[11:0]] = arg[31:16];
        mmem[11'(msp - 32'd1)] = arg[15:0];
        msp = msp - 32'd2;
      end
      OP_INT: begin
        mq.push_back({1'b1, msp, arg[31:16]});
        mq.push_back({1'b1, msp - 32'd1, arg[15:0]});
        mq.push_back({1'b1, msp - 32'd2, {12'h000, fl}});
        mmem[msp[11:0]] = arg[31:16];
        mmem[12'(msp - 32'd1)] = arg[15:0];
        mmem[12'(msp - 32'd2)] = {12'h000, fl};
        msp = msp - 32'd3;
        pulse_exp++;
      end
      OP_RET: begin
        mq.push_back({1'b0, msp + 32'd1, 16'h0000});
        mq.push_back({1'b0, msp + 32'd2, 16'h0000});
        rq.push_back({mmem[12'(msp + 32'd2)], mmem[12'(msp + 32'd1)], 1'b0, mflags});
        msp = msp + 32'd2;
      end
      default: begin
        mq.push_back({1'b0, msp + 32'd1, 16'h0000});
        mq.push_back({1'b0, msp + 32'd2, 16'h0000});
        mq.push_back({1'b0, msp + 32'd3, 16'h0000});
        mflags = mmem[12'(msp + 32'd1)][3:0];
        rq.push_back({mmem[12'(msp + 32'd3)], mmem[12'(msp + 32'd2)], 1'b1, mflags});
        msp = msp + 32'd3;
      end
    endcase
  endtask

  // Counts busy cycles from the next negedge until stall_out drops.
  task automatic wait_busy(input string name, output int cyc, output int ev);
    cyc = 0;
    ev  = 0;
    forever begin
      @(negedge clk);
      if (!stall_out) break;
      cyc++;
      if (int_pulse || redirect_valid) ev = cyc;
      if (cyc > 100) begin
        check({name, "_timeout"}, 64'(cyc), 64'd0);
        break;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (stall_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (stall_out) check({name, "_idle_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic drive(input op_t op, input logic [31:0] arg, input logic [3:0] fl);
    case (op)
      OP_CALL: begin call_req = 1'b1; ret_addr = arg; end
      OP_RET:  ret_req = 1'b1;
      OP_RTI:  rti_req = 1'b1;
      default: begin int_req = 1'b1; pc_in = arg; flags_in = fl; end
    endcase
  endtask

  task automatic release_reqs();
    call_req = 1'b0;
    ret_req  = 1'b0;
    rti_req  = 1'b0;
    int_req  = 1'b0;
  endtask

  task automatic run_op(input string name, input vec_t v);
    int cyc, ev;
    wait_idle(name);
    push_exp(v.op, v.arg, v.fl);
    drive(v.op, v.arg, v.fl);
    @(posedge clk);
    #1 release_reqs();
    wait_busy(name, cyc, ev);
    check({name, "_busy"}, 64'(cyc), 64'(v.busy));
    check({name, "_event_cycle"}, 64'(ev), (v.op == OP_CALL) ? 64'd0 : 64'(v.busy));
    check({name, "_sp"}, 64'(sp), 64'(v.sp));
  endtask

  vec_t vt[10];

  initial begin
    int cyc, ev;
    vt[0] = '{OP_CALL, 32'h0001_2345, 4'h0, 2, 32'd2045};
    vt[1] = '{OP_RET,  32'h0,         4'h0, 3, 32'd2047};
    vt[2] = '{OP_INT,  32'h0000_0040, 4'hA, 4, 32'd2044};
    vt[3] = '{OP_RTI,  32'h0,         4'h0, 4, 32'd2047};
    vt[4] = '{OP_CALL, 32'hDEAD_BEEF, 4'h0, 2, 32'd2045};
    vt[5] = '{OP_CALL, 32'h1234_5678, 4'h0, 2, 32'd2043};
    vt[6] = '{OP_INT,  32'hCAFE_0001, 4'h5, 4, 32'd2040};
    vt[7] = '{OP_RTI,  32'h0,         4'h0, 4, 32'd2043};
    vt[8] = '{OP_RET,  32'h0,         4'h0, 3, 32'd2045};
    vt[9] = '{OP_RET,  32'h0,         4'h0, 3, 32'd2047};

    reset = 1'b1;
    release_reqs();
    ret_addr = '0;
    pc_in    = '0;
    flags_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_sp", 64'(sp), 64'd2047);
    check("rst_stall", 64'(stall_out), 64'd0);
    check("rst_outs", 64'({mem_if.mem_req, mem_if.mem_we, int_pulse, redirect_valid, flags_restore}), 64'd0);
    check("rst_flags_pc", 64'({flags_out, redirect_pc}), 64'd0);

    for (int i = 0; i < 10; i++) run_op($sformatf("vec%0d", i), vt[i]);

    // CALL and interrupt in the same IDLE cycle: CALL first, then the interrupt
    // saves whatever pc_in holds when it is finally accepted.
    wait_idle("callint");
    push_exp(OP_CALL, 32'h0003_0003, 4'h0);
    push_exp(OP_INT, 32'h0000_0777, 4'h6);
    drive(OP_CALL, 32'h0003_0003, 4'h0);
    drive(OP_INT, 32'hBAD0_0BAD, 4'h6);
    @(posedge clk);
    #1 release_reqs();
    pc_in = 32'h0000_0777;
    wait_busy("callint_call", cyc, ev);
    check("callint_call_busy", 64'(cyc), 64'd2);
    check("callint_call_sp", 64'(sp), 64'd2045);
    wait_busy("callint_int", cyc, ev);
    check("callint_int_busy", 64'(cyc), 64'd4);
    check("callint_int_pulse_cycle", 64'(ev), 64'd4);
    check("callint_int_sp", 64'(sp), 64'd2042);
    run_op("callint_rti", '{OP_RTI, 32'h0, 4'h0, 4, 32'd2045});
    run_op("callint_ret", '{OP_RET, 32'h0, 4'h0, 3, 32'd2047});

    // RET with two wait cycles on every read.
    run_op("wait_call", '{OP_CALL, 32'h0A0B_0C0D, 4'h0, 2, 32'd2045});
    wait_n = 2;
    run_op("wait_ret", '{OP_RET, 32'h0, 4'h0, 7, 32'd2047});
    wait_n = 0;

    // Reset while RTI sits in POP_HI: no redirect, SP back to its reset value.
    run_op("abort_int", '{OP_INT, 32'h0000_1234, 4'h3, 4, 32'd2044});
    wait_idle("abort_rti");
    mq.push_back({1'b0, msp + 32'd1, 16'h0000});
    mq.push_back({1'b0, msp + 32'd2, 16'h0000});
    rti_req = 1'b1;
    @(posedge clk);
    #1 rti_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    msp    = 32'd2047;
    mflags = 4'h0;
    @(negedge clk);
    check("abort_sp", 64'(sp), 64'd2047);
    check("abort_stall", 64'(stall_out), 64'd0);
    check("abort_flags_out", 64'(flags_out), 64'd0);
    check("abort_redirect", 64'(redirect_valid), 64'd0);
    repeat (4) @(negedge clk);
    check("abort_still_idle", 64'(stall_out), 64'd0);

    run_op("post_call", '{OP_CALL, 32'h5555_AAAA, 4'h0, 2, 32'd2045});
    run_op("post_ret", '{OP_RET, 32'h0, 4'h0, 3, 32'd2047});

    repeat (3) @(negedge clk);
    check("sb_mem_left", 64'(mq.size()), 64'd0);
    check("sb_redirect_left", 64'(rq.size()), 64'd0);
    check("sb_pulse_left", 64'(pulse_exp), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
